modport_fifo: RTL and testbench

- Single-clock synchronous FIFO that implements the write/read port set used by the team's FIFO interface and its driver/monitor modports.
- Buffers DATA_WIDTH-bit words between a producer, which drives write_en/write_data, and a consumer, which drives read_en.
- Reports write_full and read_empty status flags.
- Serves as the single-clock reference and DUT for the FIFO verification environment.

---
 rtl/modport_fifo.sv | 106 ++++++++++
 tb/tb_modport_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/modport_fifo.sv
// ---------------------------------------------------------------------------
// modport_fifo
// Single-clock synchronous FIFO. A producer pushes words with write_en /
// write_data, a consumer pops them with read_en; read_data is registered and
// updates one cycle after an accepted read. Full/empty flags are derived
// combinationally from (ADDR_WIDTH+1)-bit pointers whose MSB is a wrap bit.
//
// Parameters:
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  log2 of depth (DEPTH = 2**ADDR_WIDTH)
//
// Ports:
//   fifo_clk    in   clock, rising edge
//   fifo_rst    in   asynchronous reset, active-low
//   write_en    in   write request (accepted when not full)
//   write_data  in   word to store
//   write_full  out  FIFO holds DEPTH entries
//   read_en     in   read request (accepted when not empty)
//   read_data   out  registered read word, holds when no read is accepted
//   read_empty  out  FIFO holds 0 entries
//
// Optional build macro MODPORT_FIFO_STATUS_EN adds:
//   fill_level  out  current occupancy, 0..DEPTH
//   overflow    out  sticky: a write was attempted while full
//   underflow   out  sticky: a read was attempted while empty
// ---------------------------------------------------------------------------
module modport_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_full,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_empty
`ifdef MODPORT_FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  write_accept;
    logic                  read_accept;

    // Same low bits with differing wrap bits means the writer is a full lap ahead.
    assign read_empty = (wptr == rptr);
    assign write_full = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                        (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign write_accept = write_en & ~write_full;
    assign read_accept  = read_en & ~read_empty;

    // Storage array is deliberately not reset; reads never touch unwritten slots.
    always_ff @(posedge fifo_clk) begin
        if (write_accept) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= write_data;
        end
    end

    always_ff @(posedge fifo_clk or negedge fifo_rst) begin
        if (!fifo_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            read_data <= '0;
        end else begin
            if (write_accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (read_accept) begin
                read_data <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr      <= rptr + PTR_ONE;
            end
        end
    end

`ifdef MODPORT_FIFO_STATUS_EN
    // Modulo subtraction of wrap-bit pointers yields occupancy 0..DEPTH directly.
    assign fill_level = wptr - rptr;

    always_ff @(posedge fifo_clk or negedge fifo_rst) begin
        if (!fifo_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && write_full) begin
                overflow <= 1'b1;
            end
            if (read_en && read_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// ---------------------------------------------------------------------------
// tb_modport_fifo
// Directed self-checking bench for modport_fifo. Inputs are driven 1 ns after
// the rising edge and outputs are sampled at the same point, so each check
// sees the state produced by the preceding edge.
// Status outputs are checked when MODPORT_FIFO_STATUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_modport_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    logic                  fifo_clk;
    logic                  fifo_rst;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_full;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_empty;
`ifdef MODPORT_FIFO_STATUS_EN
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;
`endif

    int total;
    int bad;

    modport_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .fifo_clk  (fifo_clk),
        .fifo_rst  (fifo_rst),
        .write_en  (write_en),
        .write_data(write_data),
        .write_full(write_full),
        .read_en   (read_en),
        .read_data (read_data),
        .read_empty(read_empty)
`ifdef MODPORT_FIFO_STATUS_EN
        ,
        .fill_level(fill_level),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial fifo_clk = 1'b0;
    always #5 fifo_clk = ~fifo_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        write_en   = 1'b1;
        read_en    = 1'b0;
        write_data = d;
        tick();
        idle();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        write_en = 1'b0;
        read_en  = 1'b1;
        tick();
        idle();
        check(tag, read_data, exp);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        total = 0;
        bad   = 0;

        // Reset held with both requests active: nothing may change.
        fifo_rst   = 1'b0;
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_data = 8'h33;
        repeat (3) tick();
        check("rst_empty", read_empty, 1);
        check("rst_full", write_full, 0);
        check("rst_rdata", read_data, 0);
`ifdef MODPORT_FIFO_STATUS_EN
        check("rst_fill", fill_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
`endif
        idle();
        fifo_rst = 1'b1;
        tick();
        check("post_rst_empty", read_empty, 1);

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            if (i == 15) check("fill15_full", write_full, 0);
        end
        check("fill_full", write_full, 1);
        check("fill_empty", read_empty, 0);
`ifdef MODPORT_FIFO_STATUS_EN
        check("fill_level16", fill_level, 16);
        check("pre_ovf", overflow, 0);
`endif

        // Write while full is dropped.
        push(8'hAA);
        check("ovf_full", write_full, 1);
`ifdef MODPORT_FIFO_STATUS_EN
        check("ovf_flag", overflow, 1);
`endif

        // Drain in order; no 0xAA may appear.
        for (int i = 1; i <= 16; i++) begin
            pop_check("drain", 8'(i));
        end
        check("drain_empty", read_empty, 1);
        check("drain_full", write_full, 0);

        // Read while empty leaves read_data alone.
        pop_check("unf_hold", 8'h10);
        check("unf_empty", read_empty, 1);
`ifdef MODPORT_FIFO_STATUS_EN
        check("unf_flag", underflow, 1);
        check("ovf_sticky", overflow, 1);
`endif

        // Simultaneous access at 8 entries.
        for (int i = 1; i <= 8; i++) push(8'(8'h20 + i));
        for (int k = 0; k < 5; k++) begin
            write_en   = 1'b1;
            read_en    = 1'b1;
            write_data = 8'(8'h40 + k);
            tick();
            check("sim_rdata", read_data, 8'(8'h21 + k));
            check("sim_empty", read_empty, 0);
            check("sim_full", write_full, 0);
`ifdef MODPORT_FIFO_STATUS_EN
            check("sim_fill", fill_level, 8);
`endif
        end
        idle();
        // Contents now: 26,27,28,40..44. Top up to full.
        exp_q = '{8'h27, 8'h28, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h50 + i));
            exp_q.push_back(8'(8'h50 + i));
        end
        check("sim_topup_full", write_full, 1);

        // Both asserted while full: read only.
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_data = 8'hBB;
        tick();
        idle();
        check("full_both_rdata", read_data, 8'h26);
        check("full_both_full", write_full, 0);
        while (exp_q.size() > 0) begin
            pop_check("full_both_drain", exp_q.pop_front());
        end
        check("full_both_empty", read_empty, 1);

        // Both asserted while empty: write only, no fall-through.
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_data = 8'hCC;
        tick();
        idle();
        check("empty_both_rdata", read_data, 8'h57);
        check("empty_both_empty", read_empty, 0);
        pop_check("empty_both_pop", 8'hCC);
        check("empty_both_after", read_empty, 1);

        // Alternating write/read across several pointer wraps.
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            check("wrap_wr_empty", read_empty, 0);
            check("wrap_wr_full", write_full, 0);
            pop_check("wrap_rdata", 8'(i));
            check("wrap_rd_empty", read_empty, 1);
        end

        // Asynchronous reset mid-cycle with 5 entries stored.
        for (int i = 1; i <= 5; i++) push(8'(8'h60 + i));
        check("mid_pre_empty", read_empty, 0);
        #2;
        fifo_rst = 1'b0;
        #1;
        check("mid_rst_empty", read_empty, 1);
        check("mid_rst_rdata", read_data, 0);
        check("mid_rst_full", write_full, 0);
`ifdef MODPORT_FIFO_STATUS_EN
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_unf", underflow, 0);
`endif
        @(negedge fifo_clk);
        fifo_rst = 1'b1;
        tick();
        push(8'h5A);
        check("mid_wr_empty", read_empty, 0);
        pop_check("mid_rdata", 8'h5A);
        check("mid_end_empty", read_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
